tx_slot_scheduler: RTL

TDMA transmit scheduler sitting between the per-node packet generators (`rewardv2` control/reward packets and the local data path) and the shared radio transmitter. It keeps the frame/slot counters, arbitrates the two transmit requesters, and issues the one-cycle `okToSend`-style grant only inside a legal slot window. It then holds the radio busy until the transmission completes.

---
 rtl/tx_slot_scheduler.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/tx_slot_scheduler.sv
// tx_slot_scheduler: TDMA slot/frame counters, fixed-priority ctrl/data arbitration,
// registered one-cycle grants inside the slot start window, and radio ownership tracking.
// Optional BUSY watchdog (tx_abort / sticky tx_err) is built when TX_TIMEOUT_EN is defined.
module tx_slot_scheduler #(
    parameter int unsigned SLOT_CYCLES  = 16,
    parameter int unsigned NUM_SLOTS    = 64,
    parameter int unsigned START_WINDOW = 4,
    parameter int unsigned TX_TIMEOUT   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       frame_sync,
    input  logic [5:0] myTimeslot,
    input  logic       low_E,
    input  logic       route_valid,
    input  logic       req_ctrl,
    input  logic       req_data,
    input  logic       tx_done,
    output logic       grant_ctrl,
    output logic       grant_data,
    output logic       tx_busy,
    output logic       tx_kind,
    output logic [5:0] cur_slot,
    output logic       tx_abort,
    output logic       tx_err
);
    localparam int unsigned CycleW = $clog2(SLOT_CYCLES);
    localparam int unsigned SlotW  = 6;
    localparam logic [CycleW-1:0] LastCycle = CycleW'(SLOT_CYCLES - 1);
    localparam logic [SlotW-1:0]  LastSlot  = SlotW'(NUM_SLOTS - 1);

    // Reject parameter sets the counters and watchdog cannot represent
    if (SLOT_CYCLES < 8 || (SLOT_CYCLES & (SLOT_CYCLES - 1)) != 0 || NUM_SLOTS == 0 ||
        NUM_SLOTS > 64 || START_WINDOW > SLOT_CYCLES || TX_TIMEOUT == 0) begin : gBadConfig
        $error("tx_slot_scheduler: illegal parameter set");
    end

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StGuard = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [CycleW-1:0] cycleCnt;
    logic              sentThisSlot;
    logic              boundaryNext;
    logic              windowOpen;
    logic              ctrlEligible;
    logic              dataEligible;
    logic              issueGrant;
    logic              doneCounted;
    logic              timeoutFire;
    logic              grantCtrlNext;
    logic              grantDataNext;
    logic              busyNext;
    logic              kindNext;

    // Free-running slot/frame counters; frame_sync realigns both to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cycleCnt <= '0;
            cur_slot <= '0;
        end else if (frame_sync) begin
            cycleCnt <= '0;
            cur_slot <= '0;
        end else if (cycleCnt == LastCycle) begin
            cycleCnt <= '0;
            cur_slot <= (cur_slot == LastSlot) ? '0 : cur_slot + 6'd1;
        end else begin
            cycleCnt <= cycleCnt + CycleW'(1);
        end
    end

    // Request eligibility for the current cycle; ctrl wins whenever both qualify
    always_comb begin
        boundaryNext = frame_sync || (cycleCnt == LastCycle);
        windowOpen   = en && (state == StIdle) && (32'(cycleCnt) < START_WINDOW) && !sentThisSlot;
        ctrlEligible = windowOpen && req_ctrl && ((cur_slot == '0) || (cur_slot == myTimeslot));
        dataEligible = windowOpen && req_data && (cur_slot == myTimeslot) && !low_E && route_valid;
        issueGrant   = ctrlEligible || dataEligible;
        // tx_done coinciding with the grant pulse belongs to the previous owner, not this one
        doneCounted  = (state == StBusy) && tx_done && !(grant_ctrl || grant_data);
    end

    // One grant per slot: set on grant, cleared when the next cycle starts a new slot
    always_ff @(posedge clk) begin
        if (rst) begin
            sentThisSlot <= 1'b0;
        end else if (issueGrant) begin
            sentThisSlot <= 1'b1;
        end else if (boundaryNext) begin
            sentThisSlot <= 1'b0;
        end
    end

`ifdef TX_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TX_TIMEOUT + 1);
    logic [WdW-1:0] wdCnt;

    // Watchdog: age of the current transmission, zero in the grant cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wdCnt <= '0;
        end else if (issueGrant) begin
            wdCnt <= '0;
        end else if (state == StBusy) begin
            wdCnt <= wdCnt + WdW'(1);
        end
    end

    assign timeoutFire = (state == StBusy) && !doneCounted && (wdCnt == WdW'(TX_TIMEOUT - 1));

    // Abort pulse and sticky error; reset never produces an abort
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_abort <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            tx_abort <= timeoutFire;
            if (timeoutFire) begin
                tx_err <= 1'b1;
            end
        end
    end
`else
    assign timeoutFire = 1'b0;
    assign tx_abort    = 1'b0;
    assign tx_err      = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next state: IDLE -> BUSY on grant, BUSY -> GUARD on done (or IDLE on timeout), GUARD -> IDLE
    always_comb begin
        stateNext = state;
        unique case (state)
            StIdle: begin
                if (issueGrant) begin
                    stateNext = StBusy;
                end
            end
            StBusy: begin
                if (doneCounted) begin
                    stateNext = StGuard;
                end else if (timeoutFire) begin
                    stateNext = StIdle;
                end
            end
            StGuard: stateNext = StIdle;
            default: stateNext = StIdle;
        endcase
    end

    // FSM outputs: next values of the registered grant/busy/kind outputs
    always_comb begin
        grantCtrlNext = 1'b0;
        grantDataNext = 1'b0;
        busyNext      = (stateNext != StIdle);
        kindNext      = tx_kind;
        if (issueGrant) begin
            grantCtrlNext = ctrlEligible;
            grantDataNext = !ctrlEligible;
            kindNext      = !ctrlEligible;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_ctrl <= 1'b0;
            grant_data <= 1'b0;
            tx_busy    <= 1'b0;
            tx_kind    <= 1'b0;
        end else begin
            grant_ctrl <= grantCtrlNext;
            grant_data <= grantDataNext;
            tx_busy    <= busyNext;
            tx_kind    <= kindNext;
        end
    end

endmodule
